mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single 32-bit main-memory port between the instruction-fetch requester and the load/store requester. It allows one outstanding transaction, arbitrates round-robin on conflict, counts out a fixed memory latency and returns read data or a write acknowledge to the owning requester. It sits between the multicycle core's fetch/load-store states and main memory.

## Interface
- `LATENCY`, 1: cycles from `mem_req` to valid `mem_rdata`. Legal range 1..15.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: one-cycle grant pulse to fetch.
- `if_rvalid` out 1: one-cycle pulse; `rdata` holds the instruction.
- `d_req` in 1: data request; held until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_wstrb` in 4: store byte enables.
- `d_gnt` out 1: one-cycle grant pulse to data.
- `d_rvalid` out 1: one-cycle pulse; load data on `rdata`, or store ack.
- `rdata` out 32: shared response data, registered.
- `mem_req` out 1: one-cycle memory command strobe.
- `mem_we` out 1: write command.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: write byte enables; 0 on reads.
- `mem_rdata` in 32: valid exactly `LATENCY` cycles after the `mem_req` cycle.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - No request: remain in IDLE.
  - Request pending: pick the winner, latch its command (`we`, `addr`, `wdata`, `wstrb`; fetch forces `we=0`, `wstrb=0`), set `owner` and go to ISSUE.
- Arbitration
  - Exactly one of `if_req`/`d_req` high: that requester wins.
  - Both high: the winner is the port opposite `last_owner`.
  - `last_owner` updates on each grant.
  - `last_owner` resets to DATA, so fetch wins the first conflict.
- ISSUE (one cycle)
  - `mem_req=1`, `mem_*` driven from the latched command.
  - The owner's gnt = 1.
  - Latency counter loads `LATENCY-1`.
  - Next state is WAIT, or RESP directly if `LATENCY==1`.
- WAIT: the counter decrements each cycle; when the counter is 1, go to RESP.
- RESP (one cycle, arriving exactly when `mem_rdata` is valid)
  - Capture `mem_rdata` into `rdata`.
  - Pulse the owner's rvalid on the next cycle, which is IDLE.
  - For stores, the captured `rdata` is don't-care; rvalid still pulses as the ack.
- Requests asserted in any non-IDLE state wait; they are sampled only in IDLE.
- `mem_*` command outputs are 0 outside ISSUE.
- Width rules: `addr[1:0]` are dropped on `mem_addr`; no misalignment check.

## Timing
- Let T be the cycle `req` is first seen high in IDLE.
  - Grant and `mem_req`: cycle T+1.
  - `mem_rdata` valid and captured: cycle T+1+`LATENCY`.
  - rvalid and `rdata`: cycle T+2+`LATENCY`.
- Back-to-back throughput: the next grant is at T+3+`LATENCY` earliest, because the new request is sampled in the IDLE cycle that carries rvalid.
- A requester may drop `req` or change `addr` from the cycle after gnt.
- Reset value of every output is 0: `gnt`, `rvalid`, `rdata`, `mem_*`, `busy`.
- Reset while a transaction is in flight:
  - The FSM returns to IDLE and the transaction is discarded; no rvalid pulse.
  - A late `mem_rdata` is ignored.
  - `last_owner` returns to DATA.
- `if_gnt` and `d_gnt` are never high together. Likewise `if_rvalid` and `d_rvalid`.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT/RESP);
  - owner constants `OWN_IF=0`, `OWN_D=1`;
  - latency-counter width (4).
- Sub-module `rr_arb2`: combinational two-way round-robin pick from `req[1:0]` and `last_owner`.
- Everything else (FSM, command latch, counter, response register) lives in `mem_port_arbiter`.

## Test plan
- Lone fetch, `LATENCY=1`: `if_addr=0x0000_0010` at T → `if_gnt` and `mem_req` at T+1 with `mem_addr=0x10`, `mem_we=0`. Memory returns `0x0051_3093` at T+2 → `if_rvalid=1`, `rdata=0x0051_3093` at T+3.
- Store, `LATENCY=3`: `d_we=1`, `d_addr=0x103`, `d_wdata=0xDEAD_BEEF`, `d_wstrb=4'b1000` → `mem_addr=0x100`, `mem_wstrb=4'b1000` at T+1. `d_rvalid` pulses at T+5 only.
- Simultaneous `if_req` and `d_req` from reset, held continuously → grants alternate IF, D, IF, D, each exactly `LATENCY+2` cycles apart. No gnt overlap.
- Request arrives while WAIT: `d_req` rises mid-fetch → not granted until the cycle after `if_rvalid`.
- Reset asserted in WAIT, `LATENCY=4` → all outputs 0 the next cycle. No rvalid ever pulses for that transaction. A following `if_req` is granted normally.
- `LATENCY=15` sweep: counter boundary → rvalid exactly 17 cycles after `req` sampling.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// Included by the arbiter top and its round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between fetch (req[0]) and data (req[1]).
// On conflict the port that did not own the last grant wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       owner
);

    always_comb begin
        valid = |req;
        owner = OWN_IF;
        unique case (1'b1)
            (req == 2'b11): owner = ~last_owner;
            (req == 2'b10): owner = OWN_D;
            (req == 2'b01): owner = OWN_IF;
            default:        owner = OWN_IF;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the 32-bit memory port between
// instruction fetch and load/store, with fixed memory latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t           state_q;
    state_t           state_d;
    mem_cmd_t         cmd_q;
    logic             owner_q;
    logic             last_owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rdata_q;
    logic             if_rvalid_q;
    logic             d_rvalid_q;
    logic             arb_valid;
    logic             arb_owner;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    rr_arb2 u_rr (
        .req        ({d_req, if_req}),
        .last_owner (last_owner_q),
        .valid      (arb_valid),
        .owner      (arb_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (arb_valid) state_d = ISSUE;
            end
            ISSUE: begin
                state_d   = (LATENCY == 1) ? RESP : WAIT;
                if_gnt    = (owner_q == OWN_IF);
                d_gnt     = (owner_q == OWN_D);
                mem_req   = 1'b1;
                mem_we    = cmd_q.we;
                mem_addr  = cmd_q.addr;
                mem_wdata = cmd_q.wdata;
                mem_wstrb = cmd_q.wstrb;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch, latency counter and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q        <= '0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_D;
            cnt_q        <= '0;
            rdata_q      <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        owner_q      <= arb_owner;
                        last_owner_q <= arb_owner;
                        if (arb_owner == OWN_D) begin
                            cmd_q.we    <= d_we;
                            cmd_q.addr  <= {d_addr[31:2], 2'b00};
                            cmd_q.wdata <= d_wdata;
                            cmd_q.wstrb <= d_we ? d_wstrb : 4'b0000;
                        end else begin
                            cmd_q.we    <= 1'b0;
                            cmd_q.addr  <= {if_addr[31:2], 2'b00};
                            cmd_q.wdata <= '0;
                            cmd_q.wstrb <= 4'b0000;
                        end
                    end
                end
                ISSUE: cnt_q <= CNT_W'(LATENCY - 1);
                WAIT:  cnt_q <= cnt_q - CNT_W'(1);
                RESP: begin
                    rdata_q <= mem_rdata;
                    if (owner_q == OWN_IF) if_rvalid_q <= 1'b1;
                    else                   d_rvalid_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at LATENCY 1, 3, 4 and 15.
// Instances share stimulus; each has its own fixed-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] mem_resp;

    logic        if_gnt_a    [4];
    logic        if_rvalid_a [4];
    logic        d_gnt_a     [4];
    logic        d_rvalid_a  [4];
    logic [31:0] rdata_a     [4];
    logic        mem_req_a   [4];
    logic        mem_we_a    [4];
    logic [31:0] mem_addr_a  [4];
    logic [31:0] mem_wdata_a [4];
    logic [3:0]  mem_wstrb_a [4];
    logic [31:0] mem_rdata_a [4];
    logic        busy_a      [4];

    int checks = 0;
    int errors = 0;
    int lat [4] = '{1, 3, 4, 15};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 15;
        int cnt = 0;

        mem_port_arbiter #(.LATENCY(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt_a[g]),
            .if_rvalid (if_rvalid_a[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_wstrb   (d_wstrb),
            .d_gnt     (d_gnt_a[g]),
            .d_rvalid  (d_rvalid_a[g]),
            .rdata     (rdata_a[g]),
            .mem_req   (mem_req_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_wstrb (mem_wstrb_a[g]),
            .mem_rdata (mem_rdata_a[g]),
            .busy      (busy_a[g])
        );

        // Memory drives valid data only in the cycle L after mem_req.
        always @(posedge clk) begin
            if (mem_req_a[g]) cnt <= L;
            else if (cnt > 0) cnt <= cnt - 1;
        end
        assign mem_rdata_a[g] = (cnt == 1) ? mem_resp : 32'hBAD0_BAD0;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_wstrb = '0;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        mem_resp = 32'h1234_5678;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({if_gnt_a[i], if_rvalid_a[i], d_gnt_a[i], d_rvalid_a[i],
                 rdata_a[i], mem_req_a[i], mem_we_a[i], mem_addr_a[i],
                 mem_wdata_a[i], mem_wstrb_a[i], busy_a[i]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got rdata=%h busy=%b mem_req=%b exp all zero",
                         i, rdata_a[i], busy_a[i], mem_req_a[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_lone_fetch();
        do_reset();
        if_req   = 1'b1;
        if_addr  = 32'h0000_0010;
        mem_resp = 32'h0051_3093;
        cyc();
        checks++;
        if ({if_gnt_a[0], d_gnt_a[0], mem_req_a[0]} !== 3'b101) begin
            errors++;
            $display("FAIL fetch_gnt: got gnt=%b dgnt=%b mem_req=%b exp 1 0 1",
                     if_gnt_a[0], d_gnt_a[0], mem_req_a[0]);
        end
        checks++;
        if ({mem_addr_a[0], mem_we_a[0], mem_wstrb_a[0]} !== {32'h10, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL fetch_cmd: got addr=%h we=%b wstrb=%h exp 00000010 0 0",
                     mem_addr_a[0], mem_we_a[0], mem_wstrb_a[0]);
        end
        if_req  = 1'b0;
        if_addr = 32'hFFFF_FFFF;
        cyc();
        checks++;
        if ({mem_req_a[0], mem_addr_a[0], if_rvalid_a[0], if_gnt_a[0]} !== '0) begin
            errors++;
            $display("FAIL fetch_resp_cycle: got mem_req=%b addr=%h rvalid=%b gnt=%b exp 0",
                     mem_req_a[0], mem_addr_a[0], if_rvalid_a[0], if_gnt_a[0]);
        end
        cyc();
        checks++;
        if ({if_rvalid_a[0], d_rvalid_a[0], rdata_a[0]} !== {2'b10, 32'h0051_3093}) begin
            errors++;
            $display("FAIL fetch_rvalid: got rvalid=%b drvalid=%b rdata=%h exp 1 0 00513093",
                     if_rvalid_a[0], d_rvalid_a[0], rdata_a[0]);
        end
        cyc();
        checks++;
        if (if_rvalid_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rvalid_pulse: got %b exp 0", if_rvalid_a[0]);
        end
    endtask

    task automatic test_store();
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0103;
        d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'b1000;
        cyc();
        checks++;
        if ({d_gnt_a[1], if_gnt_a[1], mem_req_a[1], mem_we_a[1]} !== 4'b1011) begin
            errors++;
            $display("FAIL store_gnt: got dgnt=%b igent=%b mem_req=%b we=%b exp 1 0 1 1",
                     d_gnt_a[1], if_gnt_a[1], mem_req_a[1], mem_we_a[1]);
        end
        checks++;
        if ({mem_addr_a[1], mem_wdata_a[1], mem_wstrb_a[1]} !== {32'h100, 32'hDEAD_BEEF, 4'b1000}) begin
            errors++;
            $display("FAIL store_cmd: got addr=%h wdata=%h wstrb=%b exp 00000100 deadbeef 1000",
                     mem_addr_a[1], mem_wdata_a[1], mem_wstrb_a[1]);
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            cyc();
            checks++;
            if ({d_rvalid_a[1], if_rvalid_a[1]} !== {(k == 5), 1'b0}) begin
                errors++;
                $display("FAIL store_ack t+%0d: got drvalid=%b irvalid=%b exp %b 0",
                         k, d_rvalid_a[1], if_rvalid_a[1], (k == 5));
            end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        d_req   = 1'b1;
        d_addr  = 32'h0000_0300;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            for (int i = 0; i < 2; i++) begin
                int per;
                logic exp_if;
                logic exp_d;
                per    = lat[i] + 2;
                exp_if = ((k - 1) % per == 0) && (((k - 1) / per) % 2 == 0);
                exp_d  = ((k - 1) % per == 0) && (((k - 1) / per) % 2 == 1);
                checks++;
                if ({if_gnt_a[i], d_gnt_a[i]} !== {exp_if, exp_d}) begin
                    errors++;
                    $display("FAIL alternate[%0d] t+%0d: got if_gnt=%b d_gnt=%b exp %b %b",
                             i, k, if_gnt_a[i], d_gnt_a[i], exp_if, exp_d);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_wait_req();
        do_reset();
        if_req   = 1'b1;
        if_addr  = 32'h0000_0040;
        mem_resp = 32'h1111_2222;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 1) begin
                checks++;
                if (if_gnt_a[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL waitreq_if_gnt: got %b exp 1", if_gnt_a[2]);
                end
                if_req = 1'b0;
            end
            if (k >= 4) begin
                checks++;
                if ({d_gnt_a[2], if_rvalid_a[2]} !== {(k == 7), (k == 6)}) begin
                    errors++;
                    $display("FAIL waitreq t+%0d: got d_gnt=%b if_rvalid=%b exp %b %b",
                             k, d_gnt_a[2], if_rvalid_a[2], (k == 7), (k == 6));
                end
            end
            if (k == 6) begin
                checks++;
                if (rdata_a[2] !== 32'h1111_2222) begin
                    errors++;
                    $display("FAIL waitreq_rdata: got %h exp 11112222", rdata_a[2]);
                end
            end
            if (k == 7) begin
                checks++;
                if (mem_addr_a[2] !== 32'h0000_0200) begin
                    errors++;
                    $display("FAIL waitreq_d_addr: got %h exp 00000200", mem_addr_a[2]);
                end
            end
            if (k == 3) begin
                d_req  = 1'b1;
                d_addr = 32'h0000_0202;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        if_req   = 1'b1;
        if_addr  = 32'h0000_0080;
        mem_resp = 32'h5555_AAAA;
        cyc();
        checks++;
        if (if_gnt_a[2] !== 1'b1) begin
            errors++;
            $display("FAIL inflight_gnt: got %b exp 1", if_gnt_a[2]);
        end
        if_req = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if ({if_gnt_a[2], if_rvalid_a[2], d_gnt_a[2], d_rvalid_a[2], rdata_a[2],
             mem_req_a[2], mem_addr_a[2], busy_a[2]} !== '0) begin
            errors++;
            $display("FAIL inflight_reset_outputs: got busy=%b rdata=%h mem_req=%b exp zero",
                     busy_a[2], rdata_a[2], mem_req_a[2]);
        end
        rst = 1'b0;
        for (int k = 4; k <= 10; k++) begin
            cyc();
            checks++;
            if ({if_rvalid_a[2], d_rvalid_a[2], busy_a[2]} !== 3'b000) begin
                errors++;
                $display("FAIL inflight_discard t+%0d: got rvalid=%b drvalid=%b busy=%b exp 0",
                         k, if_rvalid_a[2], d_rvalid_a[2], busy_a[2]);
            end
        end
        if_req = 1'b1;
        d_req  = 1'b1;
        d_addr = 32'h0000_0400;
        cyc();
        checks++;
        if ({if_gnt_a[2], d_gnt_a[2], mem_addr_a[2]} !== {2'b10, 32'h80}) begin
            errors++;
            $display("FAIL inflight_regrant: got if_gnt=%b d_gnt=%b addr=%h exp 1 0 00000080",
                     if_gnt_a[2], d_gnt_a[2], mem_addr_a[2]);
        end
        clear_inputs();
    endtask

    task automatic test_lat15();
        do_reset();
        if_req   = 1'b1;
        if_addr  = 32'h0000_0084;
        mem_resp = 32'hCAFE_0015;
        cyc();
        checks++;
        if ({if_gnt_a[3], mem_addr_a[3]} !== {1'b1, 32'h84}) begin
            errors++;
            $display("FAIL lat15_gnt: got gnt=%b addr=%h exp 1 00000084",
                     if_gnt_a[3], mem_addr_a[3]);
        end
        if_req = 1'b0;
        for (int k = 2; k <= 19; k++) begin
            cyc();
            checks++;
            if ({if_rvalid_a[3], busy_a[3]} !== {(k == 17), (k <= 16)}) begin
                errors++;
                $display("FAIL lat15 t+%0d: got rvalid=%b busy=%b exp %b %b",
                         k, if_rvalid_a[3], busy_a[3], (k == 17), (k <= 16));
            end
            if (k == 17) begin
                checks++;
                if (rdata_a[3] !== 32'hCAFE_0015) begin
                    errors++;
                    $display("FAIL lat15_rdata: got %h exp cafe0015", rdata_a[3]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store();
        test_alternate();
        test_wait_req();
        test_reset_inflight();
        test_lat15();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
